// File: rtl/hkspi_responder.sv
// Housekeeping SPI responder (mode 0 target). It oversamples SCK/CSB/SDI on the
// core clock and turns command/address/data streams into byte-wide register accesses.
module hkspi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_csb,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, COMMAND, ADDRESS, DATA, DONE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, csb_sync, sdi_sync, fill;
  logic       sck_s, csb_s, sdi_s;
  logic       sck_prev, csb_prev, armed;
  logic       act_rise, act_fall, csb_fall;
  logic [2:0] bit_cnt, byte_cnt;
  logic [6:0] in_shift;
  logic [7:0] in_byte, out_shift;
  logic       cmd_wr, cmd_rd;
  logic [2:0] cmd_n;
  logic       load_pend, inc_pend, sdo_q;
  logic       byte_end, last_byte, shifting;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign csb_s    = csb_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign act_rise = sck_s & ~sck_prev & ~csb_s;
  assign act_fall = ~sck_s & sck_prev & ~csb_s;
  assign csb_fall = csb_prev & ~csb_s;
  assign in_byte  = {in_shift, sdi_s};
  assign byte_end = act_rise && (bit_cnt == 3'd7);
  assign last_byte = (cmd_n != 3'd0) && ((byte_cnt + 3'd1) == cmd_n);
  assign shifting = (state == COMMAND) || (state == ADDRESS) || (state == DATA);

  assign busy       = ~csb_s;
  assign spi_sdo_oe = (state == DATA) && cmd_rd;
  assign spi_sdo    = sdo_q & spi_sdo_oe;

  // armed is only set once CSB has been seen high with the synchronizers
  // refilled, so a frame interrupted by reset is ignored until CSB toggles.
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync <= '0;
      csb_sync <= '1;
      sdi_sync <= '0;
      fill     <= '0;
      sck_prev <= 1'b0;
      csb_prev <= 1'b1;
      armed    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      csb_sync <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
      sck_prev <= sck_s;
      csb_prev <= csb_s;
      if (fill[SYNC_STAGES-1] && csb_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (csb_fall && armed) state_next = COMMAND;
      COMMAND: if (byte_end) state_next = (in_byte[7:6] == 2'b00) ? DONE : ADDRESS;
      ADDRESS: if (byte_end) state_next = DATA;
      DATA:    if (byte_end && last_byte) state_next = DONE;
      default: state_next = state;
    endcase
    if (state != IDLE && csb_s) state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      in_shift  <= '0;
      out_shift <= '0;
      cmd_wr    <= 1'b0;
      cmd_rd    <= 1'b0;
      cmd_n     <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      load_pend <= 1'b0;
      inc_pend  <= 1'b0;
      sdo_q     <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      inc_pend  <= 1'b0;
      load_pend <= reg_re;

      if (inc_pend) begin
        reg_addr <= reg_addr + ADDR_W'(1);
        reg_re   <= cmd_rd && (state == DATA);
      end

      if (state == IDLE) begin
        bit_cnt <= '0;
        sdo_q   <= 1'b0;
      end

      if (shifting && act_rise) begin
        in_shift <= in_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if (state == COMMAND && byte_end) begin
        cmd_wr <= in_byte[7];
        cmd_rd <= in_byte[6];
        cmd_n  <= in_byte[5:3];
      end

      if (state == ADDRESS && byte_end) begin
        reg_addr <= ADDR_W'(in_byte);
        reg_re   <= cmd_rd;
        byte_cnt <= '0;
      end

      if (state == DATA && act_fall) begin
        sdo_q     <= out_shift[7];
        out_shift <= {out_shift[6:0], 1'b0};
      end

      if (state == DATA && byte_end) begin
        if (cmd_wr) begin
          reg_wdata <= in_byte;
          reg_we    <= 1'b1;
        end
        inc_pend <= 1'b1;
        byte_cnt <= byte_cnt + 3'd1;
      end

      if (load_pend) out_shift <= reg_rdata;
    end
  end

endmodule

// File: tb/tb_hkspi_responder.sv
// Directed bench for hkspi_responder: an SPI master task, a registered register
// bank, and queues of expected strobes checked as the DUT issues them.
`timescale 1ns/1ps
module tb_hkspi_responder;
  localparam int SYNC = 2;
  localparam int HALF = 60;

  logic       clock = 1'b0;
  logic       reset, spi_sck, spi_csb, spi_sdi;
  logic       spi_sdo, spi_sdo_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  always #5 clock = ~clock;

  hkspi_responder #(.SYNC_STAGES(SYNC), .ADDR_W(8)) dut (
    .clock(clock), .reset(reset), .spi_sck(spi_sck), .spi_csb(spi_csb),
    .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  int total = 0;
  int bad = 0;

  logic [7:0]  mem [256];
  logic [7:0]  model [256];
  logic [7:0]  rdata_q;
  logic        load_mem;
  logic [7:0]  exp_re [$];
  logic [15:0] exp_we [$];
  logic [7:0]  re_e;
  logic [15:0] we_e;
  logic [7:0]  rx;
  logic        oa, ol;

  assign reg_rdata = rdata_q;

  function automatic logic [7:0] preset(input int i);
    case (i)
      2:       return 8'h56;
      3:       return 8'h10;
      17:      return 8'h12;
      default: return 8'(i * 7 + 33);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register bank: read data registered on the clock reg_re is seen.
  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= preset(i);
    end else begin
      if (reg_re) rdata_q <= mem[reg_addr];
      if (reg_we) mem[reg_addr] <= reg_wdata;
    end
  end

  always @(negedge clock) begin
    if (reg_re) begin
      if (exp_re.size() == 0) check("re_extra", 32'(reg_re), 32'd0);
      else begin
        re_e = exp_re.pop_front();
        check("re_addr", 32'(reg_addr), 32'(re_e));
      end
    end
    if (reg_we) begin
      if (exp_we.size() == 0) check("we_extra", 32'(reg_we), 32'd0);
      else begin
        we_e = exp_we.pop_front();
        check("we_addr_data", 32'({reg_addr, reg_wdata}), 32'(we_e));
      end
    end
  end

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] r,
                      output logic oe_any, output logic oe_all);
    r = '0;
    oe_any = 1'b0;
    oe_all = 1'b1;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_sdi = tx[i];
      #HALF;
      r[i] = spi_sdo;
      oe_any = oe_any | spi_sdo_oe;
      oe_all = oe_all & spi_sdo_oe;
      spi_sck = 1'b1;
      #HALF;
      spi_sck = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] r;
    logic a, l;
    xfer(tx, 8, r, a, l);
  endtask

  task automatic begin_frame();
    spi_csb = 1'b0;
    #HALF;
  endtask

  task automatic end_frame(input string tag);
    #HALF;
    spi_csb = 1'b1;
    repeat (20) @(posedge clock);
    #3;
    check({tag, "_re_left"}, 32'(exp_re.size()), 32'd0);
    check({tag, "_we_left"}, 32'(exp_we.size()), 32'd0);
    check({tag, "_oe_idle"}, 32'(spi_sdo_oe), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sdo"},   32'(spi_sdo),    32'd0);
    check({tag, "_oe"},    32'(spi_sdo_oe), 32'd0);
    check({tag, "_addr"},  32'(reg_addr),   32'd0);
    check({tag, "_wdata"}, 32'(reg_wdata),  32'd0);
    check({tag, "_we"},    32'(reg_we),     32'd0);
    check({tag, "_re"},    32'(reg_re),     32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    spi_sck = 1'b0;
    spi_csb = 1'b1;
    spi_sdi = 1'b0;
    reset = 1'b1;
    load_mem = 1'b1;
    for (int i = 0; i < 256; i++) model[i] = preset(i);
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;
    load_mem = 1'b0;
    repeat (5) @(posedge clock);
    #3;

    // Stream read of address 3
    begin_frame();
    exp_re.push_back(8'd3);
    exp_re.push_back(8'd4);
    xfer(8'h40, 8, rx, oa, ol); check("t1_cmd_oe", 32'(oa), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    xfer(8'h03, 8, rx, oa, ol); check("t1_addr_oe", 32'(oa), 32'd0);
    xfer(8'h00, 8, rx, oa, ol);
    check("t1_rdata", 32'(rx), 32'h10);
    check("t1_data_oe", 32'(ol), 32'd1);
    end_frame("t1");

    // Two single-byte stream writes to address 7
    begin_frame();
    exp_we.push_back({8'h07, 8'h01}); model[7] = 8'h01;
    send(8'h80); send(8'h07); send(8'h01);
    end_frame("t2a");
    begin_frame();
    exp_we.push_back({8'h07, 8'h00}); model[7] = 8'h00;
    send(8'h80); send(8'h07); send(8'h00);
    end_frame("t2b");

    // Auto-increment read of 19 bytes from address 0
    begin_frame();
    for (int k = 0; k < 20; k++) exp_re.push_back(8'(k));
    send(8'h40); send(8'h00);
    for (int k = 0; k < 19; k++) begin
      xfer(8'h00, 8, rx, oa, ol);
      check($sformatf("t3_byte%0d", k), 32'(rx), 32'(model[k]));
    end
    end_frame("t3");

    // Write with n=1 at 0xFF: the second data byte is ignored
    begin_frame();
    exp_we.push_back({8'hFF, 8'hAA}); model[255] = 8'hAA;
    send(8'h88); send(8'hFF); send(8'hAA); send(8'hBB);
    end_frame("t4");

    // Unlimited stream write wrapping 0xFF -> 0x00
    begin_frame();
    exp_we.push_back({8'hFF, 8'h11}); model[255] = 8'h11;
    exp_we.push_back({8'h00, 8'h22}); model[0] = 8'h22;
    send(8'h80); send(8'hFF); send(8'h11); send(8'h22);
    end_frame("t5");

    // Abort after 5 data bits of a read/write byte
    begin_frame();
    exp_re.push_back(8'h0A);
    send(8'hC0); send(8'h0A);
    xfer(8'h77, 5, rx, oa, ol);
    check("t6_oe_before", 32'(ol), 32'd1);
    #HALF;
    spi_csb = 1'b1;
    repeat (SYNC + 1) @(posedge clock);
    #1;
    check("t6_oe_drop", 32'(spi_sdo_oe), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    repeat (20) @(posedge clock);
    #3;
    check("t6_we_left", 32'(exp_we.size()), 32'd0);
    check("t6_re_left", 32'(exp_re.size()), 32'd0);
    begin_frame();
    exp_re.push_back(8'd3);
    exp_re.push_back(8'd4);
    send(8'h40); send(8'h03);
    xfer(8'h00, 8, rx, oa, ol);
    check("t6_rdata", 32'(rx), 32'h10);
    end_frame("t6b");

    // Reset pulse during the address byte; rest of the frame is ignored
    begin_frame();
    send(8'h40);
    xfer(8'h03, 3, rx, oa, ol);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_all_zero("t7_rst");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #3;
    xfer(8'hFF, 8, rx, oa, ol); check("t7_oe_a", 32'(oa), 32'd0);
    xfer(8'h00, 8, rx, oa, ol); check("t7_oe_b", 32'(oa), 32'd0);
    end_frame("t7");

    // Read/write: clear address 4, then read-modify-write it
    begin_frame();
    exp_we.push_back({8'h04, 8'h00}); model[4] = 8'h00;
    send(8'h88); send(8'h04); send(8'h00);
    end_frame("t8a");
    begin_frame();
    exp_re.push_back(8'd4);
    exp_re.push_back(8'd5);
    exp_we.push_back({8'h04, 8'h5A});
    send(8'hC0); send(8'h04);
    xfer(8'h5A, 8, rx, oa, ol);
    check("t8_rdata", 32'(rx), 32'h00);
    model[4] = 8'h5A;
    end_frame("t8b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
